// File: rtl/dht11_responder.sv
// dht11_responder -- sensor-side end of the DHT11 single-wire protocol.
// Waits for a host start pulse on the open-drain bus, then drives the ACK
// pulse followed by a 40-bit frame {i_data, checksum}, bit 39 first.
//
// Ports:
//   clk       system clock
//   rst_n     asynchronous active-low reset (releases the bus immediately)
//   dht_in    raw bus level, asynchronous (2-flop synchronized internally)
//   dht_oe    1 = pull bus low, 0 = release (external pull-up)
//   i_data    {hum_int, hum_dec, temp_int, temp_dec}, latched at start accept
//   i_corrupt (only with DHT11_CKSUM_FAULT_EN) flip checksum LSB for this frame
//   o_busy    high while responding
//   o_done    one-cycle pulse when a frame completes
//   o_abort   one-cycle pulse when a response is aborted by bus contention
//
// Optional feature macro: DHT11_CKSUM_FAULT_EN (adds i_corrupt).
`timescale 1ns/1ps
module dht11_responder #(
  parameter int unsigned CLK_HZ         = 50000000,
  parameter int unsigned START_MIN_US   = 18000,
  parameter int unsigned REPLY_DELAY_US = 30
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        dht_in,
  output logic        dht_oe,
  input  logic [31:0] i_data,
`ifdef DHT11_CKSUM_FAULT_EN
  input  logic        i_corrupt,
`endif
  output logic        o_busy,
  output logic        o_done,
  output logic        o_abort
);

  localparam int unsigned TICKS_PER_US = (CLK_HZ / 1000000 >= 1) ? CLK_HZ / 1000000 : 1;

  typedef enum logic [2:0] {
    IDLE, HOST_LOW, RESP_DELAY, ACK_LOW, ACK_HIGH, BIT_LOW, BIT_HIGH, END_LOW
  } state_t;

  state_t      state, stateNext;
  logic [1:0]  syncQ;
  logic        sPrev, s, fallEdge, riseEdge;
  logic [31:0] tickCnt, usCnt, phaseUs;
  logic        lastTick, phaseEnd;
  logic [39:0] frameQ;
  logic [5:0]  bitIdx;
  logic [7:0]  cksum, cksumTx;
  logic        latch, loadIdx, decIdx, doneNext, abortNext;
  logic        doneQ, abortQ;

  // Synchronizer resets to the idle-high bus level so reset release never
  // looks like a falling edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      syncQ <= '1;
      sPrev <= 1'b1;
    end else begin
      syncQ <= {syncQ[0], dht_in};
      sPrev <= syncQ[1];
    end
  end

  assign s        = syncQ[1];
  assign fallEdge = sPrev & ~s;
  assign riseEdge = ~sPrev & s;

  assign cksum = i_data[31:24] + i_data[23:16] + i_data[15:8] + i_data[7:0];
`ifdef DHT11_CKSUM_FAULT_EN
  assign cksumTx = cksum ^ {7'b0, i_corrupt};
`else
  assign cksumTx = cksum;
`endif

  always_comb begin
    phaseUs = 32'd1;
    case (state)
      RESP_DELAY:        phaseUs = REPLY_DELAY_US;
      ACK_LOW, ACK_HIGH: phaseUs = 32'd80;
      BIT_LOW, END_LOW:  phaseUs = 32'd50;
      BIT_HIGH:          phaseUs = frameQ[bitIdx] ? 32'd70 : 32'd26;
      default:           phaseUs = 32'd1;
    endcase
  end

  assign lastTick = (tickCnt == TICKS_PER_US - 1);
  assign phaseEnd = lastTick && (usCnt == phaseUs - 32'd1);

  always_comb begin
    stateNext = state;
    latch     = 1'b0;
    loadIdx   = 1'b0;
    decIdx    = 1'b0;
    doneNext  = 1'b0;
    abortNext = 1'b0;
    case (state)
      IDLE:     if (fallEdge) stateNext = HOST_LOW;
      HOST_LOW: if (riseEdge) begin
        if (usCnt >= START_MIN_US) begin
          stateNext = RESP_DELAY;
          latch     = 1'b1;
        end else begin
          stateNext = IDLE;
        end
      end
      RESP_DELAY: begin
        if (fallEdge) begin
          stateNext = IDLE;
          abortNext = 1'b1;
        end else if (phaseEnd) stateNext = ACK_LOW;
      end
      ACK_LOW:  if (phaseEnd) stateNext = ACK_HIGH;
      ACK_HIGH: begin
        if (fallEdge) begin
          stateNext = IDLE;
          abortNext = 1'b1;
        end else if (phaseEnd) begin
          stateNext = BIT_LOW;
          loadIdx   = 1'b1;
        end
      end
      BIT_LOW:  if (phaseEnd) stateNext = BIT_HIGH;
      BIT_HIGH: begin
        if (fallEdge) begin
          stateNext = IDLE;
          abortNext = 1'b1;
        end else if (phaseEnd) begin
          if (bitIdx != 6'd0) begin
            stateNext = BIT_LOW;
            decIdx    = 1'b1;
          end else stateNext = END_LOW;
        end
      end
      END_LOW: begin
        if (phaseEnd) begin
          stateNext = IDLE;
          doneNext  = 1'b1;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= stateNext;
  end

  // Counter restarts on every state change; in HOST_LOW it saturates at the
  // start threshold so arbitrarily long host pulses stay valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tickCnt <= '0;
      usCnt   <= '0;
    end else if (stateNext != state || state == IDLE) begin
      tickCnt <= '0;
      usCnt   <= '0;
    end else if (state == HOST_LOW && usCnt >= START_MIN_US) begin
      tickCnt <= '0;
    end else if (lastTick) begin
      tickCnt <= '0;
      usCnt   <= usCnt + 32'd1;
    end else begin
      tickCnt <= tickCnt + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frameQ <= '0;
      bitIdx <= '0;
      doneQ  <= 1'b0;
      abortQ <= 1'b0;
    end else begin
      if (latch)   frameQ <= {i_data, cksumTx};
      if (loadIdx) bitIdx <= 6'd39;
      else if (decIdx) bitIdx <= bitIdx - 6'd1;
      doneQ  <= doneNext;
      abortQ <= abortNext;
    end
  end

  always_comb begin
    dht_oe = 1'b0;
    o_busy = 1'b0;
    case (state)
      ACK_LOW, BIT_LOW, END_LOW: begin
        dht_oe = 1'b1;
        o_busy = 1'b1;
      end
      RESP_DELAY, ACK_HIGH, BIT_HIGH: o_busy = 1'b1;
      default: begin
        dht_oe = 1'b0;
        o_busy = 1'b0;
      end
    endcase
  end

  assign o_done  = doneQ;
  assign o_abort = abortQ;

endmodule

// File: tb/tb_dht11_responder.sv
// Scoreboard bench for dht11_responder. Stimulus plays the host on the bus
// and pushes the expected event (frame or abort) into expQ; the monitor
// decodes dht_oe pulse widths and checks each o_done/o_abort against expQ.
// Parameters are scaled (2 ticks/us, 100 us start threshold) for run time.
`timescale 1ns/1ps
module tb_dht11_responder;

  localparam int unsigned T       = 2;
  localparam int unsigned STARTUS = 100;
  localparam int unsigned REPLYUS = 30;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        hostPull;
  logic        dhtIn;
  logic        dht_oe;
  logic [31:0] iData;
  logic        iCorrupt;
  logic        o_busy, o_done, o_abort;

  assign dhtIn = ~dht_oe & ~hostPull;

  dht11_responder #(
    .CLK_HZ(2000000),
    .START_MIN_US(STARTUS),
    .REPLY_DELAY_US(REPLYUS)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .dht_in(dhtIn),
    .dht_oe(dht_oe),
    .i_data(iData),
`ifdef DHT11_CKSUM_FAULT_EN
    .i_corrupt(iCorrupt),
`endif
    .o_busy(o_busy),
    .o_done(o_done),
    .o_abort(o_abort)
  );

  always #5 clk = ~clk;

  typedef struct { bit isAbort; bit [39:0] frame; } exp_t;
  typedef struct { bit lvl; int unsigned len; } seg_t;

  exp_t   expQ[$];
  seg_t   segQ[$];
  int     checks = 0;
  int     errors = 0;
  longint cyc = 0;
  longint releaseCyc = 0;
  longint activity = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input bit ok, input longint act, input longint req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, req);
    end
  endtask

  // ---------------- monitor ----------------
  bit          prevOe, prevBusy, prevDone;
  int unsigned runLen;
  longint      ackLat;
  int          tErr;
  bit [39:0]   dec;
  exp_t        e;

  function automatic int segBad(input int idx, input bit lvl, input int unsigned len);
    return (segQ[idx].lvl != lvl || segQ[idx].len != len) ? 1 : 0;
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      prevOe = 0; prevBusy = 0; prevDone = 0; runLen = 0;
    end else begin
      if (o_busy && !prevBusy) begin
        segQ.delete();
        runLen = 1;
        prevOe = dht_oe;
      end else if (dht_oe != prevOe) begin
        segQ.push_back('{prevOe, runLen});
        if (dht_oe && segQ.size() == 1) ackLat = cyc - releaseCyc;
        runLen = 1;
        prevOe = dht_oe;
      end else runLen++;
      if (o_busy || dht_oe) activity++;
      if (o_done && prevDone) check("done_width", 0, 2, 1);

      if (o_done || o_abort) begin
        if (expQ.size() == 0) check("unexpected_event", 0, longint'({o_done, o_abort}), 0);
        else begin
          e = expQ.pop_front();
          if (e.isAbort) begin
            check("abort_kind", o_abort && !o_done, longint'({o_done, o_abort}), 1);
            check("abort_oe", dht_oe == 0, dht_oe, 0);
            check("abort_busy", o_busy == 0, o_busy, 0);
          end else begin
            tErr = 0;
            dec  = '0;
            if (segQ.size() != 84) tErr = 100 + segQ.size();
            else begin
              tErr += segBad(0, 0, REPLYUS * T);
              tErr += segBad(1, 1, 80 * T);
              tErr += segBad(2, 0, 80 * T);
              for (int i = 0; i < 40; i++) begin
                tErr += segBad(3 + 2 * i, 1, 50 * T);
                if (segQ[4 + 2 * i].lvl != 0) tErr++;
                else if (segQ[4 + 2 * i].len == 70 * T) dec[39 - i] = 1'b1;
                else if (segQ[4 + 2 * i].len != 26 * T) tErr++;
              end
              tErr += segBad(83, 1, 50 * T);
            end
            check("done_kind", o_done && !o_abort, longint'({o_done, o_abort}), 2);
            check("frame_data", dec == e.frame, dec, e.frame);
            check("frame_timing", tErr == 0, tErr, 0);
            check("busy_at_done", o_busy == 0, o_busy, 0);
            check("ack_latency", ackLat >= REPLYUS * T + 2 && ackLat <= REPLYUS * T + 3,
                  ackLat, REPLYUS * T + 3);
          end
        end
      end
      prevBusy = o_busy;
      prevDone = o_done;
    end
  end

  // ---------------- stimulus ----------------
  task automatic hostStart(input int unsigned lowUs);
    @(negedge clk);
    hostPull = 1'b1;
    repeat (lowUs * T) @(negedge clk);
    hostPull = 1'b0;
    releaseCyc = cyc;
  endtask

  task automatic expectFrame(input bit [31:0] d, input bit [7:0] ck);
    expQ.push_back('{1'b0, {d, ck}});
  endtask

  task automatic waitDrain(input int maxCyc);
    int n = 0;
    while (expQ.size() != 0 && n < maxCyc) begin
      @(negedge clk);
      n++;
    end
    if (expQ.size() != 0) begin
      check("drain_timeout", 0, expQ.size(), 0);
      expQ.delete();
    end
    repeat (20) @(negedge clk);
  endtask

  task automatic waitOe(input bit v, input int maxCyc, input string nm);
    int n = 0;
    while (dht_oe !== v && n < maxCyc) begin
      @(negedge clk);
      n++;
    end
    if (dht_oe !== v) check(nm, 0, dht_oe, v);
  endtask

  task automatic runFrame(input bit [31:0] d, input bit [7:0] ck);
    iData = d;
    expectFrame(d, ck);
    hostStart(STARTUS + 20);
    waitDrain(15000);
  endtask

  longint act0;

  initial begin
    rst_n = 1'b0; hostPull = 1'b0; iData = '0; iCorrupt = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_oe", dht_oe == 0, dht_oe, 0);
    check("reset_busy", o_busy == 0, o_busy, 0);
    check("reset_done", o_done == 0, o_done, 0);
    check("reset_abort", o_abort == 0, o_abort, 0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    runFrame(32'h37001A05, 8'h56);

    // Short host pulse: no response at all.
    act0 = activity;
    hostStart(STARTUS / 2);
    repeat (400) @(negedge clk);
    check("short_no_activity", activity == act0, activity - act0, 0);
    check("short_busy", o_busy == 0, o_busy, 0);

    // All ones, with i_data changed after the latch.
    iData = 32'hFFFFFFFF;
    expectFrame(32'hFFFFFFFF, 8'hFC);
    hostStart(STARTUS + 20);
    repeat (10) @(negedge clk);
    iData = 32'h00000000;
    waitDrain(15000);

    runFrame(32'h80808080, 8'h00);

    // Contention in ACK_HIGH, then a fresh valid start.
    iData = 32'h12345678;
    expQ.push_back('{1'b1, 40'h0});
    hostStart(STARTUS + 20);
    waitOe(1'b1, 400, "ack_low_timeout");
    waitOe(1'b0, 400, "ack_high_timeout");
    repeat (40 * T) @(negedge clk);
    hostPull = 1'b1;
    repeat (20) @(negedge clk);
    hostPull = 1'b0;
    waitDrain(200);
    runFrame(32'h12345678, 8'h14);

    // Asynchronous reset while driving a data-bit low phase.
    iData = 32'h37001A05;
    hostStart(STARTUS + 20);
    waitOe(1'b1, 400, "rst_ack_low_timeout");
    waitOe(1'b0, 400, "rst_ack_high_timeout");
    waitOe(1'b1, 400, "rst_bit_low_timeout");
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_oe", dht_oe == 0, dht_oe, 0);
    check("async_reset_busy", o_busy == 0, o_busy, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    act0 = activity;
    repeat (300) @(negedge clk);
    check("post_reset_quiet", activity == act0, activity - act0, 0);

`ifdef DHT11_CKSUM_FAULT_EN
    iCorrupt = 1'b1;
    runFrame(32'h37001A05, 8'h57);
    iCorrupt = 1'b0;
    runFrame(32'h37001A05, 8'h56);
`endif

    check("queue_empty", expQ.size() == 0, expQ.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dht11_responder.md
Name: dht11_responder

Overview:
- Device-side (sensor) end of the DHT11 single-wire protocol.
- Watches the open-drain bus for the host start pulse, then answers with the ACK pulse and a 40-bit data frame built from a 32-bit input word.
- Used as a board-level sensor emulator and as the bench counterpart to the dht11 host reader, so fpga_core can run without a physical sensor.

Parameters:
- CLK_HZ, 50000000: clock frequency; TICKS_PER_US = CLK_HZ/1000000 (integer, ≥1).
- START_MIN_US, 18000: minimum host low time accepted as a start request.
- REPLY_DELAY_US, 30: gap from host release to the ACK low.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- dht_in  in  1  raw bus level (asynchronous; synchronized internally by 2 flops).
- dht_oe  out  1  1 = pull bus low; 0 = release (external pull-up).
- i_data  in  32  {hum_int, hum_dec, temp_int, temp_dec}, MSB first.
- o_busy  out  1  high while responding.
- o_done  out  1  one-cycle pulse when a frame is completed.
- o_abort  out  1  one-cycle pulse when a response is aborted by contention.

Behaviour:
- Reset (async, rst_n=0):
  - dht_oe=0, o_busy=0, o_done=0, o_abort=0; state=IDLE; counters and bit index cleared.
  - Asserting rst_n mid-frame releases the bus immediately, with no clock edge needed.
- Timing:
  - All durations are exact: a phase of D us holds for D*TICKS_PER_US cycles.
  - The per-state µs counter restarts on every state entry.
- Sampling: edges are detected on the synchronized bus signal s = the output of the 2-flop synchronizer, so there is 2 cycles of input latency.
- States:
  - IDLE: dht_oe=0. Falling edge of s → HOST_LOW, counter cleared.
  - HOST_LOW: count µs while s=0; the counter saturates at START_MIN_US. Rising edge of s:
    - count ≥ START_MIN_US → RESP_DELAY; latch i_data; compute cksum = (b3+b2+b1+b0) mod 256; o_busy=1.
    - otherwise → IDLE, no response, no pulses.
  - RESP_DELAY: dht_oe=0 for REPLY_DELAY_US → ACK_LOW.
  - ACK_LOW: dht_oe=1 for 80 us → ACK_HIGH.
  - ACK_HIGH: dht_oe=0 for 80 us → BIT_LOW with bit index 39.
  - BIT_LOW: dht_oe=1 for 50 us → BIT_HIGH.
  - BIT_HIGH: dht_oe=0 for 26 us if the current bit is 0, 70 us if it is 1.
    - index>0: decrement index → BIT_LOW.
    - index=0: → END_LOW.
    - Frame order: {latched i_data, cksum}, bit 39 first.
  - END_LOW: dht_oe=1 for 50 us → IDLE; dht_oe=0, o_busy=0, o_done=1 for one cycle.
- Contention:
  - Applies in RESP_DELAY, ACK_HIGH and BIT_HIGH (the bus is released in these states).
  - A falling edge of s there → IDLE, dht_oe=0, o_busy=0, o_abort=1 for one cycle.
  - That same falling edge is not treated as a new start request; a fresh falling edge is required.
- Low-driven states ignore dht_in.
- i_data changes after the latch do not affect the current frame.
- Checksum addition is 8-bit, with wrap-around and the carry discarded.
- Host low longer than START_MIN_US is still valid; no upper limit.

Optional Feature:
- Macro DHT11_CKSUM_FAULT_EN.
- Defined:
  - Adds input i_corrupt (1 bit), sampled at the data latch.
  - i_corrupt=1 → the transmitted checksum is cksum XOR 8'h01 (fault injection for host error-path testing).
  - All else unchanged.
- Undefined: the port does not exist; the checksum is always correct.

Test Plan:
- i_data=32'h37001A05; host low 18 ms, release → dht_oe rises 30 us (+2 cycles) after release; 80/80 us ACK; 40 bits decode to 37 00 1A 05 56; o_done pulses once; o_busy falls the same cycle.
- Host low 10 ms, release → dht_oe stays 0, o_busy stays 0, no o_done or o_abort.
- i_data=32'hFFFFFFFF → checksum byte 0xFC; every data-bit high phase is exactly 70*TICKS_PER_US cycles.
- Host pulls low in ACK_HIGH at +40 us → o_abort pulse, state IDLE, dht_oe=0; a subsequent valid 18 ms start yields a full frame.
- rst_n=0 while in BIT_LOW (dht_oe=1) → dht_oe=0 with no clock edge; after release, no output until a new start request.
- DHT11_CKSUM_FAULT_EN defined, i_corrupt=1, i_data=32'h37001A05 → checksum byte 0x57; with i_corrupt=0 → 0x56.
